// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel fractional clock-enable generator.
// Each channel has a phase accumulator (NCO). It emits a single-cycle
// enable on every accumulator wrap. A lock FSM suppresses the enables
// while the configuration is settling.
// Optional feature macro: CLK_ENABLE_GEN_DUTY_EN (registered phase_msb outputs).

// Per-channel NCO: accumulator, increment and phase registers, registered ce.
module clk_enable_gen_ch #(
  parameter int              ACC_W   = 32,
  parameter logic [ACC_W-1:0] INC_RST = '0
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             i_wr_inc,
  input  logic             i_wr_ph,
  input  logic             i_resync,
  input  logic             i_locked,
  input  logic [ACC_W-1:0] i_wr_data,
  output logic             o_ce,
  output logic             o_phase_msb
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_inc;
  logic [ACC_W-1:0] r_ph;
  logic             r_ce;
  logic [ACC_W:0]   w_sum;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_carry;

  assign w_sum = {1'b0, r_acc} + {1'b0, r_inc};

  // Next accumulator value. A resync reloads the phase, and a same-cycle
  // phase write wins over the old phase. The carry is killed on resync.
  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    w_carry   = w_sum[ACC_W];
    if (i_resync) begin
      w_carry   = 1'b0;
      w_acc_nxt = i_wr_ph ? i_wr_data : r_ph;
    end
  end

  // Accumulator and enable; ce is gated by the lock state from before this edge.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ce  <= 1'b0;
    end else begin
      r_acc <= w_acc_nxt;
      r_ce  <= w_carry & i_locked;
    end
  end

  // Config registers; a new increment applies from the next accumulation.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_inc <= INC_RST;
      r_ph  <= '0;
    end else begin
      if (i_wr_inc) r_inc <= i_wr_data;
      if (i_wr_ph)  r_ph  <= i_wr_data;
    end
  end

  assign o_ce = r_ce;

`ifdef CLK_ENABLE_GEN_DUTY_EN
  logic r_msb;

  // Divided ~50% duty waveform. It follows the accumulator MSB and is forced low while unlocked.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) r_msb <= 1'b0;
    else     r_msb <= r_acc[ACC_W-1] & i_locked;
  end

  assign o_phase_msb = r_msb;
`else
  assign o_phase_msb = 1'b0;
`endif

endmodule

module clk_enable_gen #(
  parameter int          NUM_CH      = 4,
  parameter int          ACC_W       = 32,
  parameter int unsigned DEFAULT_INC = 32'h0800_0000,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_ch,
  input  logic              wr_sel,
  input  logic [ACC_W-1:0]  wr_data,
  input  logic              resync,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] phase_msb,
  output logic              locked
);

  localparam logic [ACC_W-1:0] INC_RST   = ACC_W'(DEFAULT_INC);
  localparam logic [4:0]       NCH5      = 5'(NUM_CH);
  localparam logic [15:0]      LOCK_LAST = 16'(LOCK_CYCLES - 1);

  typedef enum logic {SETTLE, LOCKED} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_cnt;
  logic [15:0]       w_cnt_nxt;
  logic              w_ch_ok;
  logic              w_inc_wr;
  logic [NUM_CH-1:0] w_wr_inc;
  logic [NUM_CH-1:0] w_wr_ph;

  assign w_ch_ok  = ({1'b0, wr_ch} < NCH5);
  assign w_inc_wr = wr_en & w_ch_ok & ~wr_sel;
  assign locked   = (r_state == LOCKED);

  // Lock state register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state <= SETTLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Settle for LOCK_CYCLES edges. An increment write or a resync while locked starts settling again.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      SETTLE: begin
        if (r_cnt == LOCK_LAST) begin
          w_state_nxt = LOCKED;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      LOCKED: begin
        if (w_inc_wr || resync) begin
          w_state_nxt = SETTLE;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr_inc[i] = wr_en & w_ch_ok & ~wr_sel & (wr_ch == 4'(i));
    assign w_wr_ph[i]  = wr_en & w_ch_ok &  wr_sel & (wr_ch == 4'(i));

    clk_enable_gen_ch #(
      .ACC_W   (ACC_W),
      .INC_RST (INC_RST)
    ) u_ch (
      .refclk      (refclk),
      .rst         (rst),
      .i_wr_inc    (w_wr_inc[i]),
      .i_wr_ph     (w_wr_ph[i]),
      .i_resync    (resync),
      .i_locked    (locked),
      .i_wr_data   (wr_data),
      .o_ce        (ce[i]),
      .o_phase_msb (phase_msb[i])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Testbench for clk_enable_gen (NUM_CH=4, ACC_W=8, LOCK_CYCLES=4, DEFAULT_INC=8'h40).
// Outputs are compared every cycle against an arithmetic reference model.
// Rate, offset and lock-timing properties are also checked directly.
module tb_clk_enable_gen;
  localparam int NCH = 4;
  localparam int AW  = 8;
  localparam int LC  = 4;

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [3:0]    wr_ch = '0;
  logic          wr_sel = 1'b0;
  logic [AW-1:0] wr_data = '0;
  logic          resync = 1'b0;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] phase_msb;
  logic          locked;

  int checks = 0;
  int failures = 0;

  // reference model state
  int       m_acc [NCH];
  int       m_inc [NCH];
  int       m_ph  [NCH];
  int       m_settle;
  bit       m_locked;
  bit [NCH-1:0] m_ce;
  bit [NCH-1:0] m_msb;

  always #5 refclk = ~refclk;

  clk_enable_gen #(
    .NUM_CH      (NCH),
    .ACC_W       (AW),
    .DEFAULT_INC (32'h40),
    .LOCK_CYCLES (LC)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .resync    (resync),
    .ce        (ce),
    .phase_msb (phase_msb),
    .locked    (locked)
  );

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_inc[i] = 'h40; m_ph[i] = 0;
    end
    m_settle = 0; m_locked = 0; m_ce = '0; m_msb = '0;
  endtask

  // One rising edge of the reference: rate = inc/256, wrap -> enable next cycle.
  task automatic model_edge();
    bit was_locked = m_locked;
    bit valid = wr_en && (int'(wr_ch) < NCH);
    bit disturb = resync || (valid && !wr_sel);
    for (int i = 0; i < NCH; i++) begin
      int sum = m_acc[i] + m_inc[i];
      m_msb[i] = was_locked && (m_acc[i] >= 128);
      if (resync) begin
        m_ce[i]  = 0;
        m_acc[i] = (valid && wr_sel && int'(wr_ch) == i) ? int'(wr_data) : m_ph[i];
      end else begin
        m_ce[i]  = was_locked && (sum >= 256);
        m_acc[i] = sum % 256;
      end
    end
    if (valid) begin
      if (wr_sel) m_ph[wr_ch]  = int'(wr_data);
      else        m_inc[wr_ch] = int'(wr_data);
    end
    if (m_locked && disturb) m_settle = 0;
    else if (!m_locked)      m_settle++;
    m_locked = (m_settle >= LC);
  endtask

  function automatic logic [2*NCH:0] exp_vec();
`ifdef CLK_ENABLE_GEN_DUTY_EN
    return {m_ce, m_locked, m_msb};
`else
    return {m_ce, m_locked, {NCH{1'b0}}};
`endif
  endfunction

  task automatic tick();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit en, input int ch, input bit sel, input int data, input bit rs);
    wr_en = en; wr_ch = 4'(ch); wr_sel = sel; wr_data = AW'(data); resync = rs;
    tick();
    wr_en = 0; wr_ch = '0; wr_sel = 0; wr_data = '0; resync = 0;
  endtask

  task automatic test_reset();
    int first = 0;
    int cnt [NCH];
    model_reset();
    repeat (3) @(posedge refclk);
    #1;
    checks++;
    if ({ce, locked, phase_msb} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {ce, locked, phase_msb});
    end
    rst = 0;
    for (int k = 1; k <= 10 && first == 0; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL reset_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      if (locked === 1'b1) first = k;
    end
    checks++;
    if (first != 4) begin
      failures++; $display("FAIL reset_lock_edge got=%0d exp=4", first);
    end
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL reset_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      checks++;
      if (ce !== 4'h0 && ce !== 4'hF) begin
        failures++; $display("FAIL reset_aligned got=%h exp=0_or_F", ce);
      end
      for (int i = 0; i < NCH; i++) cnt[i] += int'(ce[i]);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (cnt[i] != 4) begin
        failures++; $display("FAIL reset_rate ch=%0d got=%0d exp=4", i, cnt[i]);
      end
    end
  endtask

  task automatic test_fractional();
    int low;
    bit h [64];
    int tot = 0;
    drive(1, 1, 0, 'h60, 0);
    low = (locked === 1'b0) ? 1 : 0;
    for (int k = 0; k < 12 && locked !== 1'b1; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL frac_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      if (locked !== 1'b1) low++;
    end
    checks++;
    if (low != 4) begin
      failures++; $display("FAIL frac_unlock_len got=%0d exp=4", low);
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL frac_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      h[k] = ce[1];
      tot += int'(ce[1]);
    end
    for (int t = 0; t <= 56; t++) begin
      int w = 0;
      for (int j = 0; j < 8; j++) w += int'(h[t+j]);
      checks++;
      if (w != 3) begin
        failures++; $display("FAIL frac_window start=%0d got=%0d exp=3", t, w);
      end
    end
    checks++;
    if (tot != 24) begin
      failures++; $display("FAIL frac_total got=%0d exp=24", tot);
    end
  endtask

  task automatic test_phase_resync();
    bit h0 [32];
    bit h2 [32];
    int n2 = 0;
    drive(1, 2, 1, 'hC0, 0);
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL phase_write_keeps_lock got=%b exp=1", locked);
    end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (locked !== 1'b0 || ce !== 4'h0) begin
      failures++; $display("FAIL resync_edge got=%b/%h exp=0/0", locked, ce);
    end
    for (int k = 0; k < 12 && locked !== 1'b1; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL phase_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL phase_relock got=%b exp=1", locked);
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL phase_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      h0[k] = ce[0]; h2[k] = ce[2]; n2 += int'(ce[2]);
    end
    checks++;
    if (n2 != 8) begin
      failures++; $display("FAIL phase_rate ch2 got=%0d exp=8", n2);
    end
    for (int t = 0; t < 29; t++) begin
      if (h2[t]) begin
        checks++;
        if (h0[t+3] !== 1'b1 || h0[t] !== 1'b0) begin
          failures++; $display("FAIL phase_lead t=%0d got=%b%b exp=10", t, h0[t+3], h0[t]);
        end
      end
    end
  endtask

  task automatic test_simul_write_resync();
    bit h0 [32];
    bit h3 [32];
    int n3 = 0;
    drive(1, 3, 1, 'h80, 1);
    for (int k = 0; k < 12 && locked !== 1'b1; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL simul_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
    end
    for (int k = 0; k < 32; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL simul_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      h0[k] = ce[0]; h3[k] = ce[3]; n3 += int'(ce[3]);
    end
    checks++;
    if (n3 != 8) begin
      failures++; $display("FAIL simul_rate ch3 got=%0d exp=8", n3);
    end
    for (int t = 0; t < 30; t++) begin
      if (h3[t]) begin
        checks++;
        if (h0[t+2] !== 1'b1 || h0[t] !== 1'b0) begin
          failures++; $display("FAIL simul_offset t=%0d got=%b%b exp=10", t, h0[t+2], h0[t]);
        end
      end
    end
  endtask

  task automatic test_edge_values();
    int n0 = 0;
    int n2 = 0;
    drive(1, 0, 0, 'h00, 0);
    drive(1, 2, 0, 'hFF, 0);
    for (int k = 0; k < 12 && locked !== 1'b1; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL edge_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
    end
    for (int k = 0; k < 256; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL edge_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      n0 += int'(ce[0]); n2 += int'(ce[2]);
    end
    checks++;
    if (n0 != 0) begin
      failures++; $display("FAIL edge_inc_zero got=%0d exp=0", n0);
    end
    checks++;
    if (n2 != 255) begin
      failures++; $display("FAIL edge_inc_max got=%0d exp=255", n2);
    end
    drive(1, 7, 0, 'h11, 0);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (locked !== 1'b1 || {ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL edge_bad_ch cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      int r = $urandom_range(0, 99);
      bit en = (r < 10);
      bit rs = (r >= 8 && r < 12);
      drive(en, $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 255), rs);
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL random cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
    end
  endtask

  task automatic test_async_reset();
    int cnt [NCH];
    for (int k = 0; k < 12 && locked !== 1'b1; k++) tick();
    #3 rst = 1;
    #1;
    checks++;
    if ({ce, locked, phase_msb} !== '0) begin
      failures++; $display("FAIL async_reset got=%h exp=0", {ce, locked, phase_msb});
    end
    model_reset();
    repeat (2) @(posedge refclk);
    #1 rst = 0;
    for (int k = 0; k < 12 && locked !== 1'b1; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL async_settle cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
    end
    checks++;
    if (locked !== 1'b1) begin
      failures++; $display("FAIL async_relock got=%b exp=1", locked);
    end
    for (int i = 0; i < NCH; i++) cnt[i] = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      checks++;
      if ({ce, locked, phase_msb} !== exp_vec()) begin
        failures++; $display("FAIL async_run cyc=%0d got=%h exp=%h", k, {ce, locked, phase_msb}, exp_vec());
      end
      for (int i = 0; i < NCH; i++) cnt[i] += int'(ce[i]);
    end
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (cnt[i] != 4) begin
        failures++; $display("FAIL async_default_inc ch=%0d got=%0d exp=4", i, cnt[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fractional();
    test_phase_resync();
    test_simul_write_resync();
    test_edge_values();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
